obc_shift_accumulator: RTL
==========================

Name: obc_shift_accumulator

Overview:
- Bit-serial OBC shift-accumulator directly downstream of the imaginary/real partial-product ROMs of the 16-point OBC DFT.
- Each bit cycle it sums the four 32-bit ROM words (Q10.21 signed) addressed by one bit-slice of the input samples.
- It folds that sum into a right-shifting accumulator, LSB slice first. On the MSB (sign) slice it subtracts the sum instead, then emits one DFT bin component.

Parameters:
- DATA_W, 32, width of each ROM word (1 sign, 10 integer, 21 fraction bits).
- BITS, 16, input sample width = number of bit-slice beats per transform; minimum 2.
- ACC_W, DATA_W+2, accumulator/result width; the +2 bits absorb the sum of four words.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new transform; loads init_offset, clears beat counter.
- init_offset  input  DATA_W  OBC offset constant (signed), sampled only on start.
- in_valid  input  1  rom0..rom3 hold a valid bit-slice this cycle.
- rom0, rom1, rom2, rom3  input  DATA_W  signed ROM words for the current bit-slice.
- busy  output  1  high while in ACCUM.
- out_valid  output  1  one-cycle pulse; result valid.
- result  output  ACC_W  signed bin component, same Q format as ROM (21 fraction bits).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, beat counter=0, busy=0, out_valid=0, result=0. Reset mid-transform discards all partial state immediately.
- sum = sign-extended rom0+rom1+rom2+rom3 at ACC_W bits; cannot overflow.
- States:
  - IDLE: busy=0. On start: acc <= sign-extended init_offset, cnt <= 0, go to ACCUM.
  - ACCUM: busy=1. Each cycle with in_valid=1:
    - If cnt < BITS-1: acc <= (acc + sum) >>> 1, arithmetic shift; the dropped LSB is truncated toward minus infinity. cnt <= cnt+1.
    - If cnt == BITS-1 (MSB beat): result <= acc - sum, no shift; out_valid <= 1 next cycle; go to IDLE.
    - in_valid=0 holds acc and cnt unchanged; gaps of any length are legal.
- The result therefore equals -D(MSB) + sum over b<BITS-1 of D_b*2^-(BITS-1-b) + offset*2^-(BITS-1), with truncation at each shift.
- Latency: result and out_valid update on the clock edge of the BITS-th accepted beat. They are visible in the following cycle, exactly BITS accepted beats after start.
- out_valid is high for exactly one cycle. result holds its value until the next completion or reset.
- start while in ACCUM aborts the current transform and restarts with the new init_offset. No out_valid is produced for the aborted transform. in_valid in the same cycle as start is ignored.
- start in the same cycle as the MSB beat: the restart wins and no out_valid is produced.
- in_valid while in IDLE is ignored; acc is unchanged.
- Counter width is clog2(BITS). cnt never wraps because the MSB beat always exits ACCUM.
- All registers sit in a single clocked process with async reset. The sum adder and the final subtract are combinational into the registers; there is no additional pipelining.

Test Plan:
- Reset/idle: hold rst_n=0 then release -> busy=0, out_valid=0, result=0. in_valid pulses in IDLE leave result at 0.
- Basic (BITS=4): offset=0, rom0=16, others 0, 4 consecutive beats -> acc 8, 12, 14. Result=-2 (ACC_W sign-extended), out_valid pulses one cycle after the 4th beat.
- Offset path (BITS=4): offset=32, all roms 0 -> result=4. Negative truncation: offset=0, rom0=32'hFFFFFFFF -> acc -1, -1, -1, result=0.
- Width/overflow: all four roms=32'h7FFFFFFF, offset=0, BITS=4 -> sum=34'h1FFFFFFFC with no wrap. Result matches a reference model: acc 34'h0FFFFFFFE, 34'h17FFFFFFD, 34'h1BFFFFFFC, then result = acc - sum, which is negative.
- Gaps and restart: insert random in_valid=0 gaps -> result identical to the gap-free run. Assert start after 2 beats -> no out_valid; the new transform completes after 4 fresh beats.
- Async reset mid-transform: drop rst_n between clock edges at beat 2 -> busy and out_valid fall immediately. A subsequent clean transform gives the correct result.

Source files
------------

// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC shift-accumulator: sums four ROM words per bit-slice and folds them
// into a right-shifting accumulator, subtracting on the sign slice to emit one bin.
module obc_shift_accumulator #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BITS   = 16,
  parameter int unsigned ACC_W  = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_W-1:0]        init_offset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        rom0,
  input  logic [DATA_W-1:0]        rom1,
  input  logic [DATA_W-1:0]        rom2,
  input  logic [DATA_W-1:0]        rom3,
  output logic                     busy,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         result
);

  localparam int unsigned CNT_W = (BITS > 2) ? $clog2(BITS) : 1;
  localparam int unsigned EXT_W = ACC_W - DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BITS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [ACC_W-1:0]         result_nxt;
  logic                     out_valid_nxt;

  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W:0]    wide_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic                     last_beat_c;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] w);
    return {{EXT_W{w[DATA_W-1]}}, w};
  endfunction

  // Four-word sum fits ACC_W; acc+sum needs one more bit before the halving shift.
  assign sum_c       = sext(rom0) + sext(rom1) + sext(rom2) + sext(rom3);
  assign wide_c      = {acc[ACC_W-1], acc} + {sum_c[ACC_W-1], sum_c};
  assign shifted_c   = ACC_W'(wide_c >>> 1);
  assign last_beat_c = (cnt == LAST_BEAT);
  assign busy        = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      result    <= result_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state: start always (re)enters ACCUM; the MSB beat returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (start)                        state_nxt = ACCUM;
        else if (in_valid && last_beat_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath/output next values; start takes priority over any beat in the same cycle.
  always_comb begin
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    result_nxt    = result;
    out_valid_nxt = 1'b0;
    if (start) begin
      acc_nxt = sext(init_offset);
      cnt_nxt = '0;
    end else if (state == ACCUM && in_valid) begin
      if (last_beat_c) begin
        result_nxt    = ACC_W'(acc - sum_c);
        out_valid_nxt = 1'b1;
      end else begin
        acc_nxt = shifted_c;
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

endmodule
